// File: rtl/mux_pkg.sv
// mux_pkg: mode encodings and select-width helper shared by the N-to-1 mux.
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting at ptr, wrapping modulo N_CH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_gnt
);
  int j;
  // Scan from farthest to nearest so the channel closest to ptr wins last.
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    j = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = (j >= N_CH) ? j - N_CH : j;
      if (req[j]) begin
        gnt = N_CH'(1) << j;
        gnt_idx = SEL_W'(j);
        any_gnt = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: registered N-to-1 stream mux with fixed-select or round-robin arbitration.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);
  logic [N_CH-1:0] arb_gnt, fix_gnt, gnt;
  logic [SEL_W-1:0] arb_idx, idx, ptr;
  logic arb_any, load_en, xfer;
  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req(in_valid),
    .ptr(ptr),
    .gnt(arb_gnt),
    .gnt_idx(arb_idx),
    .any_gnt(arb_any)
  );
  // Out-of-range sel yields no grant, so non-power-of-two N_CH never reads past in_data.
  always_comb begin
    fix_gnt = (int'(sel) < N_CH) ? (in_valid & (N_CH'(1) << sel)) : '0;
    gnt = rst ? '0 : (mode == MODE_RR) ? (arb_any ? arb_gnt : '0) : fix_gnt;
    idx = (mode == MODE_RR) ? arb_idx : sel;
    load_en = !out_valid | out_ready;
    in_ready = load_en ? gnt : '0;
    xfer = |in_ready;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= in_data[int'(idx)*DATA_W +: DATA_W];
      out_ch <= idx;
      if (mode == MODE_RR) ptr <= (int'(idx) == N_CH - 1) ? '0 : idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr: directed checks of fixed/round-robin muxing on a 4-channel and a 3-channel instance.
module tb_mux_nto1_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode4 = 1'b0, out_valid4, out_ready4 = 1'b0;
  logic [1:0] sel4 = '0, out_ch4;
  logic [31:0] in_data4 = 32'hDDCC_BBAA;
  logic [3:0] in_valid4 = '0, in_ready4;
  logic [7:0] out_data4;
  logic mode3 = 1'b0, out_valid3, out_ready3 = 1'b0;
  logic [1:0] sel3 = '0, out_ch3;
  logic [23:0] in_data3 = 24'hCC_BBAA;
  logic [2:0] in_valid3 = '0, in_ready3;
  logic [7:0] out_data3;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mux_nto1_rr #(.N_CH(4), .DATA_W(8)) u4 (
    .clk(clk), .rst(rst), .mode(mode4), .sel(sel4), .in_data(in_data4),
    .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
    .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready4)
  );
  mux_nto1_rr #(.N_CH(3), .DATA_W(8)) u3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Check in_ready mid-cycle, then the registered outputs just after the next edge.
  task automatic beat4(input string tag, input logic [3:0] rdy, input logic vld, input logic [7:0] d, input logic [1:0] ch);
    #1 chk({tag, ".in_ready"}, 32'(in_ready4), 32'(rdy));
    @(posedge clk);
    #1 chk({tag, ".out_valid"}, 32'(out_valid4), 32'(vld));
    if (vld) begin
      chk({tag, ".out_data"}, 32'(out_data4), 32'(d));
      chk({tag, ".out_ch"}, 32'(out_ch4), 32'(ch));
    end
  endtask
  task automatic beat3(input string tag, input logic [2:0] rdy, input logic vld, input logic [7:0] d, input logic [1:0] ch);
    #1 chk({tag, ".in_ready"}, 32'(in_ready3), 32'(rdy));
    @(posedge clk);
    #1 chk({tag, ".out_valid"}, 32'(out_valid3), 32'(vld));
    if (vld) begin
      chk({tag, ".out_data"}, 32'(out_data3), 32'(d));
      chk({tag, ".out_ch"}, 32'(out_ch3), 32'(ch));
    end
  endtask
  initial begin
    logic [1:0] fair_ch [5] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
    in_valid4 = 4'hF;
    repeat (2) @(posedge clk);
    #1 chk("rst.out_valid", 32'(out_valid4), 32'd0);
    chk("rst.in_ready", 32'(in_ready4), 32'd0);
    chk("rst.out_data", 32'(out_data4), 32'd0);
    rst = 1'b0;
    // fixed select 0..3, then an invalid selected channel
    out_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      beat4("fix", 4'(1 << i), 1'b1, 8'(8'hAA + 8'h11 * i), 2'(i));
    end
    sel4 = 2'd2;
    in_valid4 = 4'b1011;
    beat4("fix_noval", 4'b0000, 1'b0, 8'h00, 2'd0);
    // round robin over all channels: two full laps leave ptr at 0
    mode4 = 1'b1;
    in_valid4 = 4'hF;
    for (int i = 0; i < 8; i++)
      beat4("rr", 4'(1 << (i % 4)), 1'b1, 8'(8'hAA + 8'h11 * (i % 4)), 2'(i % 4));
    in_valid4 = 4'b1010;
    for (int i = 0; i < 5; i++)
      beat4("fair", 4'(1 << fair_ch[i]), 1'b1, (fair_ch[i] == 2'd1) ? 8'hBB : 8'hDD, fair_ch[i]);
    // hold BB from channel 1 under back-pressure
    out_ready4 = 1'b0;
    for (int i = 0; i < 3; i++) beat4("bp", 4'b0000, 1'b1, 8'hBB, 2'd1);
    out_ready4 = 1'b1;
    #1 chk("bp.held_valid", 32'(out_valid4), 32'd1);
    beat4("bp_rel", 4'b1000, 1'b1, 8'hDD, 2'd3);
    in_valid4 = 4'b0000;
    beat4("drain", 4'b0000, 1'b0, 8'h00, 2'd0);
    // async reset mid-cycle with a beat held
    mode4 = 1'b0;
    sel4 = 2'd0;
    in_valid4 = 4'hF;
    out_ready4 = 1'b0;
    beat4("pre_rst", 4'b0001, 1'b1, 8'hAA, 2'd0);
    #3 rst = 1'b1;
    #1 chk("arst.out_valid", 32'(out_valid4), 32'd0);
    chk("arst.out_data", 32'(out_data4), 32'd0);
    chk("arst.out_ch", 32'(out_ch4), 32'd0);
    chk("arst.in_ready", 32'(in_ready4), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid4 = 4'b0000;
    // 3-channel instance: round-robin wraps 2 -> 0
    mode3 = 1'b1;
    in_valid3 = 3'b111;
    out_ready3 = 1'b1;
    beat3("rr3_0", 3'b001, 1'b1, 8'hAA, 2'd0);
    beat3("rr3_1", 3'b010, 1'b1, 8'hBB, 2'd1);
    beat3("rr3_2", 3'b100, 1'b1, 8'hCC, 2'd2);
    beat3("rr3_3", 3'b001, 1'b1, 8'hAA, 2'd0);
    in_valid3 = 3'b000;
    beat3("drain3", 3'b000, 1'b0, 8'h00, 2'd0);
    mode3 = 1'b0;
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    beat3("fix3_oob", 3'b000, 1'b0, 8'h00, 2'd0);
    sel3 = 2'd2;
    beat3("fix3_2", 3'b100, 1'b1, 8'hCC, 2'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
Parametrised N-to-1 multiplexer with a registered output and a valid/ready handshake on every channel. It supports two modes: fixed-select (software-steered) and round-robin arbitration across all channels. It is the sequential, multi-channel successor to the 4:1 combinational mux and sits between N producer streams and a single consumer.

Parameters:
N_CH, 4, number of input channels (2..16; need not be a power of two)
DATA_W, 8, data width per channel
SEL_W, $clog2(N_CH), select/channel-index width (derived; not overridden)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_data  input  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  input  N_CH  per-channel valid
in_ready  output  N_CH  per-channel ready (one-hot or zero)
out_data  output  DATA_W  registered data
out_ch  output  SEL_W  index of the channel that supplied out_data
out_valid  output  1  output register holds data
out_ready  input  1  consumer accepts

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. in_ready is combinational and is 0 while rst is high.
- load_en = !out_valid | out_ready. Output register loads only when load_en=1 and a grant exists.
- Grant (combinational):
  - Fixed mode: grant = sel if sel < N_CH and in_valid[sel]; otherwise no grant.
  - RR mode: grant = first i with in_valid[i], scanning ptr, ptr+1, ... with wrap modulo N_CH (correct for non-power-of-two N_CH).
- in_ready[g] = load_en & granted(g). All other in_ready bits are 0. A transfer occurs when in_valid[g] & in_ready[g].
- On transfer: out_data <= channel g data, out_ch <= g, out_valid <= 1. In RR mode, ptr <= (g+1) mod N_CH, wrapping N_CH-1 to 0.
- Output handshake: out_valid=1 & out_ready=1 with no new transfer -> out_valid <= 0. Simultaneous drain and load in the same cycle -> new data, out_valid stays 1 (full throughput, 1 beat/cycle).
- Latency: 1 cycle from input acceptance to out_valid.
- Back-pressure: out_valid=1 & out_ready=0 -> all in_ready=0. Output is held stable (data, ch, valid).
- ptr is updated only by RR-mode transfers. It is not touched in fixed mode and is not reset by a mode change.
- mode and sel are sampled per cycle. A change takes effect on the next grant computation, and a held output beat is unaffected.
- No valid inputs -> no grant, and the register drains normally.
- rst asserted mid-stream: the output beat is discarded immediately (out_valid=0 asynchronously).

Decomposition:
- Package mux_pkg: mode encoding constants MODE_FIXED=1'b0, MODE_RR=1'b1. The SEL_W derivation is a function clog2_min1 that returns at least 1.
- Sub-module rr_arbiter (N_CH): inputs req and ptr; outputs one-hot gnt, gnt_idx and any_gnt. It is purely combinational. The pointer register lives in mux_nto1_rr.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately, and all in_ready=0 while rst is high.
- Fixed mode, N_CH=4, DATA_W=8, in_data={8'hDD,8'hCC,8'hBB,8'hAA}, all valid, out_ready=1, sel stepping 0,1,2,3 -> out_data AA,BB,CC,DD with out_ch 0..3, each 1 cycle after sel. Then sel=2 with in_valid[2]=0 -> in_ready=0, out_valid drops.
- RR mode, all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1, one beat per cycle, and in_ready one-hot rotating.
- RR fairness: in_valid=4'b1010 -> out_ch alternates 1,3,1,3. After out_ch=3, ptr wraps to 0 and the next grant is 1.
- Back-pressure: out_ready=0 for 3 cycles holding out_data=8'hBB -> output stable, in_ready=0. Then out_ready=1 with a new beat -> drain and reload the same cycle with out_valid continuously 1.
- N_CH=3 (non-power-of-two), RR, all valid -> out_ch 0,1,2,0. In fixed mode, sel=3 -> no grant and out_valid stays 0.
